// File: rtl/bayer_line_sequencer_pkg.sv
// Shared definitions for the Bayer line sequencer: default geometry, FSM state
// type and the pipeline latency that downstream alignment logic relies on.
package bayer_pkg;

    localparam int unsigned PIX_W_DEF    = 10;
    localparam int unsigned MAX_LINE_DEF = 1024;
    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned CNT_W_DEF    = 12;

    // Cycles from pixel acceptance to D0/D1/X/Y/DATA_EN.
    localparam int unsigned LATENCY = 2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitLine = 2'd1,
        StActive   = 2'd2
    } state_e;

endpackage

// File: rtl/bayer_line_sequencer_if.sv
// Camera-side inputs and demosaic-side outputs of the Bayer line sequencer.
interface bayer_line_sequencer_if #(
    parameter int unsigned PIX_W = 10,
    parameter int unsigned CNT_W = 12
) ();

    logic             iFVAL;
    logic             iLVAL;
    logic [PIX_W-1:0] iDATA;
    logic [PIX_W-1:0] D0;
    logic [PIX_W-1:0] D1;
    logic             X;
    logic             Y;
    logic             DATA_EN;
    logic             FRAME_START;
    logic [CNT_W-1:0] LINE_CNT;
    logic             OVERFLOW;

    modport master (
        output iFVAL, iLVAL, iDATA,
        input  D0, D1, X, Y, DATA_EN, FRAME_START, LINE_CNT, OVERFLOW
    );

    modport slave (
        input  iFVAL, iLVAL, iDATA,
        output D0, D1, X, Y, DATA_EN, FRAME_START, LINE_CNT, OVERFLOW
    );

endinterface

// File: rtl/bayer_line_sequencer_line_buf.sv
// One-line history buffer: single-port, read-first synchronous RAM with no
// reset so it maps onto block RAM.
module line_buf #(
    parameter int unsigned PIX_W    = 10,
    parameter int unsigned MAX_LINE = 1024,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem_q [MAX_LINE];

    always_ff @(posedge CLK) begin
        rdata <= mem_q[addr];
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/bayer_line_sequencer.sv
// Qualifies the FVAL/LVAL camera stream, tracks column/row and presents the
// current and previous-line pixel pair to the demosaic stage.
module bayer_line_sequencer
    import bayer_pkg::*;
#(
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned MAX_LINE = MAX_LINE_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    bayer_line_sequencer_if.slave  bus
);

    // One extra bit so the column can sit at MAX_LINE once a line overflows.
    localparam int unsigned       COL_W   = ADDR_W + 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_LINE);
    localparam logic [CNT_W-1:0] ROW_MAX = '1;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic               ovf_q, ovf_d;
    logic               fs_q, fs_d;
    logic               fval_q;
    logic               accept;
    logic               in_range;

    logic               s1_vld_q, s1_we_q, s1_en_q, s1_x_q, s1_y_q;
    logic [PIX_W-1:0]   s1_data_q;
    logic [ADDR_W-1:0]  s1_addr_q;
    logic               s2_vld_q, s2_en_q, s2_x_q, s2_y_q;
    logic [PIX_W-1:0]   s2_data_q;
    logic [PIX_W-1:0]   rdata;

    logic [PIX_W-1:0]   d0_q, d1_q;
    logic               x_q, y_q, en_q;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        ovf_d    = ovf_q;
        fs_d     = 1'b0;
        accept   = 1'b0;
        in_range = (col_q < COL_MAX);

        case (state_q)
            StIdle: begin
                if (bus.iFVAL && !fval_q) begin
                    state_d = StWaitLine;
                    col_d   = '0;
                    row_d   = '0;
                    ovf_d   = 1'b0;
                    fs_d    = 1'b1;
                end
            end
            StWaitLine: begin
                if (!bus.iFVAL) begin
                    state_d = StIdle;
                end else if (bus.iLVAL) begin
                    state_d = StActive;
                    accept  = 1'b1;
                end
            end
            StActive: begin
                // A frame drop during a line discards the partial line.
                if (!bus.iFVAL) begin
                    state_d = StIdle;
                    col_d   = '0;
                end else if (bus.iLVAL) begin
                    accept = 1'b1;
                end else begin
                    state_d = StWaitLine;
                    col_d   = '0;
                    row_d   = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            col_d = in_range ? col_q + 1'b1 : col_q;
            if (!in_range) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            ovf_q     <= 1'b0;
            fs_q      <= 1'b0;
            // Reset high so an FVAL already asserted at release is not a rise.
            fval_q    <= 1'b1;
            s1_vld_q  <= 1'b0;
            s1_we_q   <= 1'b0;
            s1_en_q   <= 1'b0;
            s1_x_q    <= 1'b0;
            s1_y_q    <= 1'b0;
            s1_data_q <= '0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_en_q   <= 1'b0;
            s2_x_q    <= 1'b0;
            s2_y_q    <= 1'b0;
            s2_data_q <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ovf_q     <= ovf_d;
            fs_q      <= fs_d;
            fval_q    <= bus.iFVAL;

            s1_vld_q  <= accept;
            s1_we_q   <= accept && in_range;
            s1_en_q   <= accept && in_range && (row_q != '0);
            s1_x_q    <= col_q[0];
            s1_y_q    <= row_q[0];
            s1_data_q <= bus.iDATA;
            s1_addr_q <= col_q[ADDR_W-1:0];

            s2_vld_q  <= s1_vld_q;
            s2_en_q   <= s1_en_q;
            s2_x_q    <= s1_x_q;
            s2_y_q    <= s1_y_q;
            s2_data_q <= s1_data_q;

            en_q      <= s2_en_q;
            if (s2_vld_q) begin
                d0_q <= s2_data_q;
                d1_q <= rdata;
                x_q  <= s2_x_q;
                y_q  <= s2_y_q;
            end
        end
    end

    line_buf #(
        .PIX_W    (PIX_W),
        .MAX_LINE (MAX_LINE),
        .ADDR_W   (ADDR_W)
    ) u_line_buf (
        .CLK   (CLK),
        .we    (s1_we_q),
        .addr  (s1_addr_q),
        .wdata (s1_data_q),
        .rdata (rdata)
    );

    assign bus.D0          = d0_q;
    assign bus.D1          = d1_q;
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.DATA_EN     = en_q;
    assign bus.FRAME_START = fs_q;
    assign bus.LINE_CNT    = row_q;
    assign bus.OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_bayer_line_sequencer.sv
// Directed bench for bayer_line_sequencer with an 8-pixel line buffer; every
// output is logged per cycle and checked against hand-computed values.
module tb_bayer_line_sequencer;

    localparam int unsigned PW = 10;
    localparam int unsigned CW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bayer_line_sequencer_if #(.PIX_W(PW), .CNT_W(CW)) bus ();

    bayer_line_sequencer #(
        .PIX_W    (PW),
        .MAX_LINE (8),
        .ADDR_W   (3),
        .CNT_W    (CW)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [PW-1:0] log_d0 [1024];
    logic [PW-1:0] log_d1 [1024];
    logic          log_x  [1024];
    logic          log_y  [1024];
    logic          log_en [1024];
    logic          log_ovf[1024];

    // Drive one cycle at a negedge, sample all outputs at the next negedge.
    task automatic step(input logic fv, input logic lv, input logic [PW-1:0] dat);
        bus.iFVAL = fv;
        bus.iLVAL = lv;
        bus.iDATA = dat;
        @(negedge clk);
        log_d0[cyc]  = bus.D0;
        log_d1[cyc]  = bus.D1;
        log_x[cyc]   = bus.X;
        log_y[cyc]   = bus.Y;
        log_en[cyc]  = bus.DATA_EN;
        log_ovf[cyc] = bus.OVERFLOW;
        cyc++;
    endtask

    task automatic drive_line(input int n, input int base, output int start);
        start = cyc;
        for (int c = 0; c < n; c++) step(1'b1, 1'b1, PW'(base + c));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.iFVAL = 1'b0;
        bus.iLVAL = 1'b0;
        bus.iDATA = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.D0, bus.D1} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %0h expected 0", {bus.D0, bus.D1});
        end
        n_vec++;
        if ({bus.X, bus.Y, bus.DATA_EN, bus.FRAME_START, bus.OVERFLOW} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.X, bus.Y, bus.DATA_EN, bus.FRAME_START, bus.OVERFLOW});
        end
        n_vec++;
        if (bus.LINE_CNT !== '0) begin
            n_err++;
            $display("FAIL reset_line_cnt: got %0d expected 0", bus.LINE_CNT);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
    endtask

    task automatic test_frame();
        int st[4];
        step(1'b1, 1'b0, '0);
        n_vec++;
        if (bus.FRAME_START !== 1'b1) begin
            n_err++;
            $display("FAIL frame_start_pulse: got %b expected 1", bus.FRAME_START);
        end
        step(1'b1, 1'b0, '0);
        n_vec++;
        if (bus.FRAME_START !== 1'b0) begin
            n_err++;
            $display("FAIL frame_start_width: got %b expected 0", bus.FRAME_START);
        end
        for (int r = 0; r < 4; r++) begin
            drive_line(8, r * 16, st[r]);
            gap(2);
        end
        step(1'b0, 1'b0, '0);
        n_vec++;
        if (bus.LINE_CNT !== CW'(4)) begin
            n_err++;
            $display("FAIL frame_line_cnt: got %0d expected 4", bus.LINE_CNT);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                int k = st[r] + c + 2;
                n_vec++;
                if (log_en[k] !== (r != 0)) begin
                    n_err++;
                    $display("FAIL frame_en r%0d c%0d: got %b expected %b", r, c, log_en[k],
                             (r != 0));
                end
                n_vec++;
                if (log_d0[k] !== PW'(r * 16 + c) || log_x[k] !== c[0] || log_y[k] !== r[0])
                begin
                    n_err++;
                    $display("FAIL frame_d0xy r%0d c%0d: got %0d/%b/%b expected %0d/%b/%b", r, c,
                             log_d0[k], log_x[k], log_y[k], r * 16 + c, c[0], r[0]);
                end
                if (r > 0) begin
                    n_vec++;
                    if (log_d1[k] !== PW'((r - 1) * 16 + c)) begin
                        n_err++;
                        $display("FAIL frame_d1 r%0d c%0d: got %0d expected %0d", r, c,
                                 log_d1[k], (r - 1) * 16 + c);
                    end
                end
            end
            if (r > 0) begin
                n_vec++;
                if (log_en[st[r] + 10] !== 1'b0) begin
                    n_err++;
                    $display("FAIL frame_en_drop r%0d: got %b expected 0", r, log_en[st[r] + 10]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int a, b, c2;
        step(1'b1, 1'b0, '0);
        n_vec++;
        if (bus.FRAME_START !== 1'b1 || bus.LINE_CNT !== '0) begin
            n_err++;
            $display("FAIL ovf_frame_start: got fs=%b cnt=%0d expected fs=1 cnt=0",
                     bus.FRAME_START, bus.LINE_CNT);
        end
        step(1'b1, 1'b0, '0);
        drive_line(8, 0, a);
        gap(2);
        drive_line(10, 100, b);
        gap(2);
        drive_line(8, 200, c2);
        gap(2);
        n_vec++;
        if (log_ovf[b + 7] !== 1'b0 || log_ovf[b + 8] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_col8: got %b%b expected 01", log_ovf[b + 7], log_ovf[b + 8]);
        end
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (log_en[b + c + 2] !== (c < 8)) begin
                n_err++;
                $display("FAIL ovf_en c%0d: got %b expected %b", c, log_en[b + c + 2], (c < 8));
            end
        end
        for (int c = 0; c < 8; c++) begin
            n_vec++;
            if (log_d1[c2 + c + 2] !== PW'(100 + c) || log_d0[c2 + c + 2] !== PW'(200 + c)) begin
                n_err++;
                $display("FAIL ovf_next_line c%0d: got d0=%0d d1=%0d expected d0=%0d d1=%0d", c,
                         log_d0[c2 + c + 2], log_d1[c2 + c + 2], 200 + c, 100 + c);
            end
        end
        step(1'b0, 1'b0, '0);
        n_vec++;
        if (bus.OVERFLOW !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sticky: got %b expected 1", bus.OVERFLOW);
        end
        step(1'b1, 1'b0, '0);
        n_vec++;
        if (bus.OVERFLOW !== 1'b0 || bus.FRAME_START !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_clear: got ovf=%b fs=%b expected ovf=0 fs=1", bus.OVERFLOW,
                     bus.FRAME_START);
        end
    endtask

    task automatic test_abort();
        int a, b, n;
        step(1'b1, 1'b0, '0);
        drive_line(8, 300, a);
        gap(2);
        drive_line(5, 400, b);
        step(1'b0, 1'b1, PW'(405));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        n_vec++;
        if (bus.LINE_CNT !== CW'(1)) begin
            n_err++;
            $display("FAIL abort_line_cnt: got %0d expected 1", bus.LINE_CNT);
        end
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (log_d1[b + c + 2] !== PW'(300 + c) || log_en[b + c + 2] !== 1'b1) begin
                n_err++;
                $display("FAIL abort_partial c%0d: got d1=%0d en=%b expected d1=%0d en=1", c,
                         log_d1[b + c + 2], log_en[b + c + 2], 300 + c);
            end
        end
        n_vec++;
        if (log_en[b + 7] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_col5_dropped: got %b expected 0", log_en[b + 7]);
        end
        step(1'b1, 1'b0, '0);
        n_vec++;
        if (bus.FRAME_START !== 1'b1 || bus.LINE_CNT !== '0) begin
            n_err++;
            $display("FAIL abort_restart: got fs=%b cnt=%0d expected fs=1 cnt=0",
                     bus.FRAME_START, bus.LINE_CNT);
        end
        step(1'b1, 1'b0, '0);
        drive_line(8, 500, n);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int c = 0; c < 8; c++) begin
            n_vec++;
            if (log_en[n + c + 2] !== 1'b0 || log_y[n + c + 2] !== 1'b0 ||
                log_d0[n + c + 2] !== PW'(500 + c)) begin
                n_err++;
                $display("FAIL abort_row0 c%0d: got en=%b y=%b d0=%0d expected en=0 y=0 d0=%0d",
                         c, log_en[n + c + 2], log_y[n + c + 2], log_d0[n + c + 2], 500 + c);
            end
        end
        n_vec++;
        if (bus.LINE_CNT !== '0) begin
            n_err++;
            $display("FAIL abort_simul_fall: got %0d expected 0", bus.LINE_CNT);
        end
    endtask

    task automatic test_reset_midline();
        int a, b;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        drive_line(8, 600, a);
        gap(1);
        drive_line(4, 700, b);
        step(1'b1, 1'b1, PW'(704));
        step(1'b1, 1'b1, PW'(705));
        n_vec++;
        if (bus.D0 !== PW'(703) || bus.D1 !== PW'(603) || bus.DATA_EN !== 1'b1 ||
            bus.LINE_CNT !== CW'(1)) begin
            n_err++;
            $display("FAIL pre_reset: got d0=%0d d1=%0d en=%b cnt=%0d expected 703 603 1 1",
                     bus.D0, bus.D1, bus.DATA_EN, bus.LINE_CNT);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.D0, bus.D1, bus.X, bus.Y, bus.DATA_EN, bus.FRAME_START, bus.LINE_CNT,
             bus.OVERFLOW} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got d0=%0d d1=%0d cnt=%0d flags=%b expected all 0",
                     bus.D0, bus.D1, bus.LINE_CNT,
                     {bus.X, bus.Y, bus.DATA_EN, bus.FRAME_START, bus.OVERFLOW});
        end
        bus.iLVAL = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0);
            n_vec++;
            if (bus.FRAME_START !== 1'b0) begin
                n_err++;
                $display("FAIL no_start_after_reset %0d: got %b expected 0", i, bus.FRAME_START);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, PW'(i + 1));
        step(1'b1, 1'b0, '0);
        n_vec++;
        if (bus.DATA_EN !== 1'b0) begin
            n_err++;
            $display("FAIL no_accept_in_idle: got %b expected 0", bus.DATA_EN);
        end
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        n_vec++;
        if (bus.FRAME_START !== 1'b1) begin
            n_err++;
            $display("FAIL start_after_new_rise: got %b expected 1", bus.FRAME_START);
        end
    endtask

    task automatic test_back_to_back();
        int a, b, c;
        step(1'b1, 1'b0, '0);
        drive_line(8, 40, a);
        gap(1);
        drive_line(8, 80, b);
        gap(1);
        drive_line(4, 120, c);
        gap(2);
        step(1'b0, 1'b0, '0);
        n_vec++;
        if (log_en[b + 9] !== 1'b1 || log_en[b + 10] !== 1'b0 || log_en[c + 2] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_en_gap: got %b%b%b expected 101", log_en[b + 9], log_en[b + 10],
                     log_en[c + 2]);
        end
        n_vec++;
        if (log_x[b + 9] !== 1'b1 || log_x[c + 2] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_x_restart: got %b%b expected 10", log_x[b + 9], log_x[c + 2]);
        end
        n_vec++;
        if (log_y[b + 9] !== 1'b1 || log_y[c + 2] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_y_toggle: got %b%b expected 10", log_y[b + 9], log_y[c + 2]);
        end
        n_vec++;
        if (log_d0[c + 2] !== PW'(120) || log_d1[c + 2] !== PW'(80)) begin
            n_err++;
            $display("FAIL b2b_line2_col0: got d0=%0d d1=%0d expected d0=120 d1=80",
                     log_d0[c + 2], log_d1[c + 2]);
        end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (log_d1[b + k + 2] !== PW'(40 + k)) begin
                n_err++;
                $display("FAIL b2b_d1 c%0d: got %0d expected %0d", k, log_d1[b + k + 2], 40 + k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_abort();
        test_reset_midline();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
